// File: rtl/add_subb_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | add_subb_seq : multi-word add/subtract using one W-bit slice per cycle,  |
// |                least-significant word first. ADD_SUBB_SEQ_BTB_EN enables |
// |                back-to-back issue from DONE.                             |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module add_subb_seq #(
    parameter int W = 8,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           subb_a,
    input  logic           subb_b,
    input  logic [N*W-1:0] a,
    input  logic [N*W-1:0] b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*W-1:0] s,
    output logic           c
);

    localparam int                 c_CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [N*W-1:0]       x_q, x_d;
    logic [N*W-1:0]       y_q, y_d;
    logic [N*W-1:0]       s_q, s_d;
    logic [c_CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]           carry_q, carry_d;
    logic                 c_q, c_d;

    logic                 w_accept;
    logic [W-1:0]         w_x;
    logic [W-1:0]         w_y;
    logic [W+1:0]         w_sum;
    logic [1:0]           w_cin0;

    // Operands are stored already conditionally inverted; the +1 terms of the
    // two's-complement negations enter as the initial carry (0..2).
    assign w_cin0 = {1'b0, subb_a} + {1'b0, subb_b};

    assign w_x   = x_q[int'(cnt_q)*W +: W];
    assign w_y   = y_q[int'(cnt_q)*W +: W];
    assign w_sum = {2'b00, w_x} + {2'b00, w_y} + {{W{1'b0}}, carry_q};

`ifdef ADD_SUBB_SEQ_BTB_EN
    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
`else
    assign in_ready = (state_q == IDLE);
`endif

    assign w_accept  = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign s         = s_q;
    assign c         = c_q;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        c_d     = c_q;

        case (state_q)
            IDLE: begin
            end
            RUN: begin
                s_d[int'(cnt_q)*W +: W] = w_sum[W-1:0];
                carry_d                 = w_sum[W+1:W];
                if (cnt_q == c_LAST) begin
                    c_d     = |w_sum[W+1:W];
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Acceptance is only possible from IDLE, or from a retiring DONE.
        if (w_accept) begin
            x_d     = subb_a ? ~a : a;
            y_d     = subb_b ? ~b : b;
            cnt_d   = '0;
            carry_d = w_cin0;
            state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 2'b00;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            c_q     <= c_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_add_subb_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_add_subb_seq : self-checking bench for add_subb_seq (W=8, N=4).       |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
module tb_add_subb_seq;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int NW = W * N;

`ifdef ADD_SUBB_SEQ_BTB_EN
    localparam bit BTB = 1'b1;
`else
    localparam bit BTB = 1'b0;
`endif

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic          subb_a    = 1'b0;
    logic          subb_b    = 1'b0;
    logic [NW-1:0] a         = '0;
    logic [NW-1:0] b         = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [NW-1:0] s;
    logic          c;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    add_subb_seq #(.W(W), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .subb_a    (subb_a),
        .subb_b    (subb_b),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .c         (c)
    );

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endfunction

    // Full-width reference: whole-operand arithmetic, no word slicing.
    function automatic void ref_op(input logic [NW-1:0] xa, input logic [NW-1:0] xb,
                                   input logic sa, input logic sb,
                                   output logic [NW-1:0] rs, output logic rc);
        logic [NW+1:0] t;
        t  = {2'b00, (sa ? ~xa : xa)} + {2'b00, (sb ? ~xb : xb)}
           + (NW+2)'(sa) + (NW+2)'(sb);
        rs = t[NW-1:0];
        rc = |t[NW+1:NW];
    endfunction

    // Transaction-level model: an accepted op yields its result N edges later
    // and is held until the consumer takes it.
    bit            m_pend = 1'b0;
    bit            m_done = 1'b0;
    int            m_left = 0;
    logic [NW-1:0] m_s    = '0;
    logic          m_c    = 1'b0;
    logic [NW-1:0] m_ps   = '0;
    logic          m_pc   = 1'b0;

    always @(posedge clk) begin : model
        bit rdy;
        bit acc;
        if (!rst_n) begin
            m_pend = 1'b0;
            m_done = 1'b0;
            m_left = 0;
            m_s    = '0;
            m_c    = 1'b0;
        end else begin
            rdy = (!m_pend && !m_done) || (BTB && m_done && out_ready);
            acc = in_valid && rdy;
            if (m_done && out_ready) m_done = 1'b0;
            if (m_pend) begin
                m_left--;
                if (m_left == 0) begin
                    m_pend = 1'b0;
                    m_done = 1'b1;
                    m_s    = m_ps;
                    m_c    = m_pc;
                end
            end
            if (acc) begin
                ref_op(a, b, subb_a, subb_b, m_ps, m_pc);
                m_pend = 1'b1;
                m_left = N;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", in_ready, (!m_pend && !m_done) || (BTB && m_done && out_ready));
            chk("out_valid", out_valid, m_done);
            if (!m_pend) begin
                chk("s", s, m_s);
                chk("c", c, m_c);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!in_ready && k < 50) begin
            step();
            k++;
        end
        if (!in_ready) chk("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (!out_valid && k < 20) begin
            step();
            k++;
        end
        chk({name, "_latency"}, k, N);
    endtask

    task automatic run_op(input string name, input logic [NW-1:0] ta, input logic [NW-1:0] ob,
                          input logic sa, input logic sb,
                          input logic [NW-1:0] es, input logic ec);
        wait_ready();
        a         = ta;
        b         = ob;
        subb_a    = sa;
        subb_b    = sb;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        wait_valid(name);
        chk({name, "_s"}, s, es);
        chk({name, "_c"}, c, ec);
        step();
    endtask

    initial begin
        repeat (3) step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_s", s, 0);
        chk("rst_c", c, 0);
        chk_en = 1'b1;
        rst_n  = 1'b1;
        step();

        run_op("add",      32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0);
        run_op("add_wrap", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1);
        run_op("sub",      32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0);
        run_op("neg_both", 32'h00000001, 32'h00000001, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b1);

        // Backpressure with a new request waiting.
        wait_ready();
        a = 32'h1; b = 32'h2; subb_a = 1'b0; subb_b = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        wait_valid("bp");
        chk("bp_s", s, 32'h3);
        a = 32'hAAAA0000; b = 32'h00005555;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_s", s, 32'h3);
            chk("bp_hold_c", c, 0);
            chk("bp_hold_ready", in_ready, 0);
            chk("bp_hold_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, BTB);
        step();
        if (!BTB) begin
            chk("bp_idle_valid", out_valid, 0);
            chk("bp_idle_ready", in_ready, 1);
            step();
        end
        in_valid = 1'b0;
        chk("bp_new_running", in_ready, 0);
        wait_valid("bp_new");
        chk("bp_new_s", s, 32'hAAAA5555);
        chk("bp_new_c", c, 0);
        step();

        // Reset while word 2 is being processed.
        wait_ready();
        a = 32'hDEADBEEF; b = 32'h01020304;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        chk("midrst_valid", out_valid, 0);
        chk("midrst_s", s, 0);
        chk("midrst_c", c, 0);
        chk("midrst_ready", in_ready, 1);
        rst_n = 1'b1;
        run_op("post_rst", 32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            a         = (i % 7 == 0) ? '1 : NW'($urandom);
            b         = (i % 5 == 0) ? NW'(1) : NW'($urandom);
            subb_a    = 1'($urandom_range(0, 1));
            subb_b    = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/add_subb_seq.md
Name: add_subb_seq

Overview:
- Multi-word sequencer for a W-bit add/subtract slice.
- Computes a full N*W-bit signed-operand add/subtract one W-bit word per cycle, least-significant word first. The inter-word carry is held in a register.
- Sits between the BKM FPU control path and its wide mantissa/exponent operands, so the FPU uses a narrow adder for wide arithmetic.
- Valid/ready handshake on both the operand side and the result side.

Parameters:
- W, 8, slice width in bits (W >= 2).
- N, 4, number of words per operand (N >= 1); operand width is N*W.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- in_valid  input  1  operand request valid
- in_ready  output  1  block can accept an operation
- subb_a  input  1  1: negate operand a (two's complement)
- subb_b  input  1  1: negate operand b (two's complement)
- a  input  N*W  operand a
- b  input  N*W  operand b
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- s  output  N*W  result
- c  output  1  carry flag: 1 iff final inter-word carry is nonzero

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset is synchronous and active-low on rst_n: sampled on the rising edge of clk; no asynchronous path.
- Arithmetic:
  - s = ((subb_a ? ~a : a) + (subb_b ? ~b : b) + subb_a + subb_b) mod 2^(N*W).
  - Word i: sum_i = x_i + y_i + cin_i, computed W+2 bits wide.
  - cin_0 = subb_a + subb_b (0..2); cin_i = sum_{i-1}[W+1:W].
  - Carry register is 2 bits. c = |carry after word N-1.
- Operand capture: a, b, subb_a and subb_b are registered on acceptance. Input changes after acceptance have no effect.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. If in_valid=1: capture operands, word counter=0, carry=cin_0, go to RUN.
  - RUN: process word[counter] and write s word[counter]. Update carry, then counter++. When counter==N-1, go to DONE.
  - DONE: out_valid=1; s and c held stable. If out_ready=1, go to IDLE.
- Latency: acceptance at edge t0 gives out_valid=1 after edge t0+N. Throughput without the optional feature is one operation per N+2 cycles minimum.
- in_ready is 1 only in IDLE; it is a registered-state decode with no combinational dependence on in_valid.
- N=1: RUN lasts exactly one cycle.
- Backpressure: DONE is held indefinitely while out_ready=0. in_ready stays 0, and s/c do not change.
- in_valid while busy is ignored; the request is not latched.
- Reset values (any state, including mid-RUN): state=IDLE, in_ready=1 (after reset), out_valid=0, s=0, c=0, counter=0, carry=0. The partial operation is discarded.
- Counter width: clog2(N), minimum 1 bit. No wrap-around beyond N-1.

Optional Feature:
- Macro: ADD_SUBB_SEQ_BTB_EN (back-to-back issue).
- Defined:
  - in_ready=1 also in DONE when out_ready=1 (combinational from out_ready).
  - In DONE with out_ready=1 and in_valid=1: result retires and new operands are captured in the same cycle. Next state is RUN, not IDLE.
  - Steady-state throughput is one operation per N+1 cycles.
- Undefined: in_ready is asserted only in IDLE, as described above.

Test Plan:
- W=8, N=4, add: a=0x000000FF, b=0x00000001 -> after 4 cycles out_valid=1, s=0x00000100, c=0.
- Add with wrap: a=0xFFFFFFFF, b=0x00000001 -> s=0x00000000, c=1.
- Subtract: subb_b=1, a=5, b=7 -> s=0xFFFFFFFE, c=0.
- Both negated: subb_a=subb_b=1, a=1, b=1 -> s=0xFFFFFFFE, c=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid, with in_valid=1 and new operands driven:
  - s/c stable and in_ready=0 throughout;
  - new op accepted only after out_ready=1 and return to IDLE;
  - with ADD_SUBB_SEQ_BTB_EN, accepted in the retire cycle.
- Reset mid-RUN: rst_n=0 at word 2 of an operation -> next edge out_valid=0, s=0, c=0, in_ready=1. A fresh op 0x12345678+0x11111111 then gives s=0x23456789, c=0.
